row_xfer: RTL and testbench

Miss-service engine for the emulated DRAM row cache. While the row cache holds its `hold` output high on a read or write miss, this block moves a whole row between the backing memory and the assigned cache slot: it writes back a dirty victim if needed, then fills the slot. It then pulses `sync` to release the cache. It sits directly downstream of the row cache's `hold`/`cRowId` outputs and drives the cache's `sync` input.

---
 rtl/row_xfer.sv | 138 +++++++++++++
 tb/tb_row_xfer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_xfer.sv
// row_xfer: miss-service engine for the emulated DRAM row cache.
// While the row cache holds `hold`, optionally writes back the dirty victim
// row (cache array -> backing memory), then fills the assigned slot
// (backing memory -> cache array), then pulses `sync` for one cycle.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   hold, cRowId, RowId        miss request, target slot, row to fill
//   victim_dirty, victim_row   writeback needed, victim row address
//   sync, busy                 completion pulse, transfer in progress
//   mem_req/we/row/col/wdata   beat request to backing memory
//   mem_ack, mem_rdata         beat accept, read data (valid with ack)
//   cache_re/we/slot/col/wdata cache-array access
//   cache_rdata                array read data, one cycle after cache_re
//   miss_cnt                   completed transfers, saturating
module row_xfer #(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 4,
    parameter int DWIDTH    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic [CHWIDTH-1:0]   cRowId,
    input  logic [ADDRWIDTH-1:0] RowId,
    input  logic                 victim_dirty,
    input  logic [ADDRWIDTH-1:0] victim_row,
    output logic                 sync,
    output logic                 busy,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDRWIDTH-1:0] mem_row,
    output logic [COLWIDTH-1:0]  mem_col,
    output logic [DWIDTH-1:0]    mem_wdata,
    input  logic                 mem_ack,
    input  logic [DWIDTH-1:0]    mem_rdata,
    output logic                 cache_re,
    output logic                 cache_we,
    output logic [CHWIDTH-1:0]   cache_slot,
    output logic [COLWIDTH-1:0]  cache_col,
    output logic [DWIDTH-1:0]    cache_wdata,
    input  logic [DWIDTH-1:0]    cache_rdata,
    output logic [15:0]          miss_cnt
);

    typedef enum logic [2:0] {IDLE, WB_RD, WB_REQ, FILL, DONE} state_t;

    state_t                state;
    logic [COLWIDTH-1:0]   col;
    logic [CHWIDTH-1:0]    slot_q;
    logic [ADDRWIDTH-1:0]  row_q;
    logic [ADDRWIDTH-1:0]  vrow_q;
    logic [DWIDTH-1:0]     wdata_q;
    logic                  wd_fresh;   // first WB_REQ cycle of a beat
    logic                  col_max;

    assign col_max = &col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col      <= '0;
            slot_q   <= '0;
            row_q    <= '0;
            vrow_q   <= '0;
            wdata_q  <= '0;
            wd_fresh <= 1'b0;
            miss_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hold) begin
                        slot_q <= cRowId;
                        row_q  <= RowId;
                        vrow_q <= victim_row;
                        col    <= '0;
                        state  <= victim_dirty ? WB_RD : FILL;
                    end
                end
                WB_RD: begin
                    wd_fresh <= 1'b1;
                    state    <= WB_REQ;
                end
                WB_REQ: begin
                    // Capture the array data once; it is held from here on
                    // even if the array output moves while unacked.
                    wd_fresh <= 1'b0;
                    if (wd_fresh)
                        wdata_q <= cache_rdata;
                    if (mem_ack) begin
                        if (col_max) begin
                            col   <= '0;
                            state <= FILL;
                        end else begin
                            col   <= col + 1'b1;
                            state <= WB_RD;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        col <= col + 1'b1;
                        if (col_max)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (miss_cnt != 16'hFFFF)
                        miss_cnt <= miss_cnt + 16'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state flops, so they are all zero
    // the instant reset forces IDLE.
    assign sync     = (state == DONE);
    assign busy     = (state != IDLE);
    assign mem_we   = (state == WB_REQ);
    assign mem_req  = (state == WB_REQ) || (state == FILL);
    assign mem_row  = (state == WB_REQ) ? vrow_q :
                      (state == FILL)   ? row_q  : '0;
    assign mem_col  = mem_req ? col : '0;
    // Array data arrives in the first WB_REQ cycle; pass it through then so
    // an immediate ack costs no extra cycle, afterwards use the held copy.
    assign mem_wdata = (state != WB_REQ) ? '0 :
                       wd_fresh ? cache_rdata : wdata_q;

    assign cache_re    = (state == WB_RD);
    assign cache_we    = (state == FILL) && mem_ack;
    assign cache_slot  = (cache_re || cache_we) ? slot_q : '0;
    assign cache_col   = (cache_re || cache_we) ? col : '0;
    assign cache_wdata = cache_we ? mem_rdata : '0;

endmodule

// File: tb/tb_row_xfer.sv
// Self-checking bench for row_xfer: scoreboard queues for memory write
// beats and cache-array writes, a backing-memory / cache-array model,
// and one task per scenario.
module tb_row_xfer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic [4:0]  cRowId = '0;
    logic [16:0] RowId = '0;
    logic        victim_dirty = 1'b0;
    logic [16:0] victim_row = '0;
    logic        sync, busy, mem_req, mem_we;
    logic [16:0] mem_row;
    logic [3:0]  mem_col;
    logic [63:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        cache_re, cache_we;
    logic [4:0]  cache_slot;
    logic [3:0]  cache_col;
    logic [63:0] cache_wdata;
    logic [63:0] cache_rdata = '0;
    logic [15:0] miss_cnt;

    row_xfer dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .cRowId(cRowId), .RowId(RowId),
        .victim_dirty(victim_dirty), .victim_row(victim_row),
        .sync(sync), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cache_re(cache_re), .cache_we(cache_we), .cache_slot(cache_slot),
        .cache_col(cache_col), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0] a;
        logic [4:0]  s;
        logic [3:0]  c;
        logic [63:0] d;
    } exp_t;

    exp_t        wq[$];
    exp_t        cq[$];
    logic [63:0] cmem [32][16];
    int          checks = 0;
    int          errors = 0;
    int          sync_cnt = 0;
    int          cw_cnt = 0;
    int          ack_mode = 0;     // 0 tied high, 1 ~30% random, 2 never
    logic [15:0] exp_cnt = '0;

    logic        re_pend = 1'b0;
    logic [4:0]  re_slot;
    logic [3:0]  re_col;
    logic        prev_wait = 1'b0;
    logic [16:0] p_row;
    logic [3:0]  p_col;
    logic        p_we;
    logic [63:0] p_wd;

    function automatic logic [63:0] rd_pat(input logic [16:0] r, input logic [3:0] c);
        return {15'h0, r, 28'hA5A5A5A, c};
    endfunction

    // Memory / array responder: acts just after each rising edge.
    always @(posedge clk) begin
        #1;
        cache_rdata = re_pend ? cmem[re_slot][re_col] : 64'hDEAD_BEEF_0BAD_F00D;
        re_pend = 1'b0;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = ($urandom_range(0, 9) < 3);
            default: mem_ack = 1'b0;
        endcase
        mem_rdata = rd_pat(mem_row, mem_col);
    end

    // Monitor: compares beats against the scoreboard away from the edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait = 1'b0;
            re_pend   = 1'b0;
        end else begin
            if (prev_wait) begin
                checks++;
                if (!mem_req || mem_row !== p_row || mem_col !== p_col ||
                    mem_we !== p_we || mem_wdata !== p_wd) begin
                    errors++;
                    $display("FAIL stable: got req=%b row=%h col=%h we=%b wd=%h need row=%h col=%h we=%b wd=%h",
                             mem_req, mem_row, mem_col, mem_we, mem_wdata, p_row, p_col, p_we, p_wd);
                end
            end
            prev_wait = mem_req && !mem_ack;
            p_row = mem_row; p_col = mem_col; p_we = mem_we; p_wd = mem_wdata;

            if (mem_req && mem_ack && mem_we) begin
                exp_t e;
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL wb_beat: unexpected row=%h col=%h data=%h", mem_row, mem_col, mem_wdata);
                end else begin
                    e = wq.pop_front();
                    if ({mem_row, 5'd0, mem_col, mem_wdata} !== e) begin
                        errors++;
                        $display("FAIL wb_beat: got row=%h col=%h data=%h need row=%h col=%h data=%h",
                                 mem_row, mem_col, mem_wdata, e.a, e.c, e.d);
                    end
                end
            end
            if (cache_we) begin
                exp_t e;
                checks++;
                cw_cnt++;
                cmem[cache_slot][cache_col] = cache_wdata;
                if (cq.size() == 0) begin
                    errors++;
                    $display("FAIL fill_beat: unexpected slot=%h col=%h data=%h", cache_slot, cache_col, cache_wdata);
                end else begin
                    e = cq.pop_front();
                    if ({17'd0, cache_slot, cache_col, cache_wdata} !== e) begin
                        errors++;
                        $display("FAIL fill_beat: got slot=%h col=%h data=%h need slot=%h col=%h data=%h",
                                 cache_slot, cache_col, cache_wdata, e.s, e.c, e.d);
                    end
                end
            end
            if (cache_re) begin
                re_pend = 1'b1;
                re_slot = cache_slot;
                re_col  = cache_col;
            end
            if (sync) sync_cnt++;
        end
    end

    // Stimulus: queue expectations, present the miss, let edge t sample it.
    task automatic start_miss(input logic [4:0] s, input logic [16:0] r,
                              input logic d, input logic [16:0] vr);
        for (int k = 0; k < 16; k++) begin
            if (d) wq.push_back({vr, 5'd0, 4'(k), cmem[s][k]});
            cq.push_back({17'd0, s, 4'(k), rd_pat(r, 4'(k))});
        end
        @(negedge clk);
        cRowId = s; RowId = r; victim_dirty = d; victim_row = vr; hold = 1'b1;
        @(posedge clk);
    endtask

    // Negedges after the sampling edge until sync is seen; 0 on timeout.
    task automatic wait_sync(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (sync) begin
                lat = i;
                hold = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({sync, busy, mem_req, mem_we, cache_re, cache_we, mem_row, mem_col,
             mem_wdata, cache_slot, cache_col, cache_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs req=%b row=%h wd=%h need all zero", mem_req, mem_row, mem_wdata);
        end
        checks++;
        if (miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h need 0", miss_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_check(input string name, input int lat, input int need_lat);
        repeat (3) @(negedge clk);
        checks++;
        if (lat != need_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d need %0d", name, lat, need_lat);
        end
        checks++;
        if (wq.size() != 0 || cq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got wq=%0d cq=%0d left need 0", name, wq.size(), cq.size());
        end
        checks++;
        if (sync_cnt != 1) begin
            errors++;
            $display("FAIL %s_sync_count: got %0d need 1", name, sync_cnt);
        end
        exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
        checks++;
        if (miss_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_miss_cnt: got %h need %h", name, miss_cnt, exp_cnt);
        end
    endtask

    task automatic test_clean();
        int lat;
        ack_mode = 0; sync_cnt = 0;
        start_miss(5'd3, 17'h1ABCD, 1'b0, 17'h0);
        wait_sync(100, lat);
        finish_check("clean", lat, 17);
    endtask

    task automatic test_dirty();
        int lat;
        ack_mode = 0; sync_cnt = 0;
        start_miss(5'd0, 17'h0F00F, 1'b1, 17'h00042);
        wait_sync(200, lat);
        finish_check("dirty", lat, 49);
    endtask

    task automatic test_backpressure();
        int lat;
        ack_mode = 1; sync_cnt = 0; cw_cnt = 0;
        start_miss(5'd9, 17'h1FFFF, 1'b1, 17'h00155);
        wait_sync(3000, lat);
        ack_mode = 0;
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL bp_done: got no sync within 3000 cycles need sync");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cw_cnt != 16 || sync_cnt != 1 || wq.size() != 0 || cq.size() != 0) begin
            errors++;
            $display("FAIL bp_counts: got writes=%0d syncs=%0d wq=%0d cq=%0d need 16 1 0 0",
                     cw_cnt, sync_cnt, wq.size(), cq.size());
        end
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (miss_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL bp_miss_cnt: got %h need %h", miss_cnt, exp_cnt);
        end
    endtask

    task automatic test_churn();
        int lat;
        int busy_seen = 0;
        ack_mode = 0; sync_cnt = 0;
        start_miss(5'd5, 17'h00AAA, 1'b0, 17'h0);
        repeat (5) @(negedge clk);
        cRowId = 5'd12; RowId = 17'h00001; victim_dirty = 1'b1;
        victim_row = 17'h1F0F0; hold = 1'b0;
        wait_sync(100, lat);
        checks++;
        if (lat + 5 != 17) begin
            errors++;
            $display("FAIL churn_latency: got %0d need 17", lat + 5);
        end
        repeat (30) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || sync_cnt != 1 || cq.size() != 0) begin
            errors++;
            $display("FAIL churn_single: got busy_cycles=%0d syncs=%0d cq=%0d need 0 1 0",
                     busy_seen, sync_cnt, cq.size());
        end
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (miss_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL churn_miss_cnt: got %h need %h", miss_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit hit = 0;
        ack_mode = 2; sync_cnt = 0;
        @(negedge clk);
        cRowId = 5'd2; RowId = 17'h00123; victim_dirty = 1'b1;
        victim_row = 17'h00077; hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rstmid_reach: got no WB_REQ within 10 cycles need WB_REQ");
        end
        hold = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sync, busy, mem_req, mem_we, cache_re, cache_we, mem_row, mem_col,
             mem_wdata, cache_slot, cache_col, cache_wdata} !== '0 || miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got req=%b we=%b row=%h cnt=%h need all zero",
                     mem_req, mem_we, mem_row, miss_cnt);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        checks++;
        if (sync_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_nosync: got %0d syncs need 0", sync_cnt);
        end
        ack_mode = 0;
        start_miss(5'd1, 17'h02468, 1'b0, 17'h0);
        wait_sync(100, lat);
        finish_check("rstmid_fresh", lat, 17);
    endtask

    task automatic test_saturation();
        int lat;
        @(negedge clk);
        force dut.miss_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.miss_cnt;
        exp_cnt = 16'hFFFE;
        @(negedge clk);
        checks++;
        if (miss_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sat_preload: got %h need %h", miss_cnt, exp_cnt);
        end
        sync_cnt = 0;
        start_miss(5'd30, 17'h10001, 1'b0, 17'h0);
        wait_sync(100, lat);
        finish_check("sat_first", lat, 17);
        sync_cnt = 0;
        start_miss(5'd31, 17'h10002, 1'b1, 17'h0ABCD);
        wait_sync(200, lat);
        finish_check("sat_hold", lat, 49);
    endtask

    initial begin
        for (int s = 0; s < 32; s++)
            for (int k = 0; k < 16; k++)
                cmem[s][k] = 64'((s << 8) | k);
        test_reset();
        test_clean();
        test_dirty();
        test_backpressure();
        test_churn();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1);
    end

endmodule
